// File: rtl/i2s_rx_controller_pkg.sv
// Shared constants for the I2S receive controller: default geometry,
// capture FSM state encoding and a pointer-width helper.
package i2s_rx_controller_pkg;

    localparam int DEF_NUMBER_OF_BITS      = 8;
    localparam int DEF_HALF_FRAME_CYCLES   = 32;
    localparam int DEF_SAMPLES_BUFFER_SIZE = 10;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DELAY = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;

    // Width needed to address a buffer of the given depth, never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/i2s_rx_controller_ws_divider.sv
// Word-select generator: counts half-frame clock cycles and toggles ws
// on the wrap cycle. Deasserting enable freezes both count and ws.
module i2s_rx_controller_ws_divider
    import i2s_rx_controller_pkg::*;
#(
    parameter int HALF_FRAME_CYCLES = DEF_HALF_FRAME_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic ws
);

    localparam int                CNT_W = ptr_width(HALF_FRAME_CYCLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(HALF_FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Half-frame counter; ws flips on the same edge the counter wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ws    <= 1'b0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
                ws    <= ~ws;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_controller.sv
// I2S receive controller: generates ws, captures one MSB-first word per
// ws half-period after the I2S one-bit delay, and presents it on a
// valid/ready output with a frame-buffer write pointer and sticky overflow.
//
// state | meaning
// IDLE  | waiting for a ws transition to start a word
// DELAY | the I2S one-bit delay slot, data_in ignored
// SHIFT | shifting in NUMBER_OF_BITS data bits, MSB first
module i2s_rx_controller
    import i2s_rx_controller_pkg::*;
#(
    parameter int NUMBER_OF_BITS      = DEF_NUMBER_OF_BITS,
    parameter int HALF_FRAME_CYCLES   = DEF_HALF_FRAME_CYCLES,
    parameter int SAMPLES_BUFFER_SIZE = DEF_SAMPLES_BUFFER_SIZE,
    localparam int PTR_W              = ptr_width(SAMPLES_BUFFER_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      data_in,
    output logic                      ws,
    output logic [NUMBER_OF_BITS-1:0] sample_data,
    output logic                      sample_channel,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic [PTR_W-1:0]          wr_ptr,
    output logic                      overflow,
    input  logic                      overflow_clear
);

    localparam int               BC_W     = ptr_width(NUMBER_OF_BITS);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(NUMBER_OF_BITS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SAMPLES_BUFFER_SIZE - 1);

    logic [1:0]                state;
    logic [BC_W-1:0]           bit_cnt;
    logic [NUMBER_OF_BITS-1:0] shift_reg;
    logic                      channel;
    logic                      word_done;
    logic                      ws_prev;
    logic                      ws_edge;
    logic                      accept;
    logic                      load;
    logic                      drop;

    i2s_rx_controller_ws_divider #(
        .HALF_FRAME_CYCLES (HALF_FRAME_CYCLES)
    ) u_ws_divider (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .ws     (ws)
    );

    assign ws_edge = (ws != ws_prev);
    assign accept  = sample_valid & sample_ready;
    // A finished word goes out if the output slot is free or being emptied
    // this cycle; otherwise it is lost and flagged.
    assign load    = word_done & (~sample_valid | sample_ready);
    assign drop    = word_done & sample_valid & ~sample_ready;

    // Delayed copy of ws for transition detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_prev <= 1'b0;
        end else begin
            ws_prev <= ws;
        end
    end

    // Capture FSM and shifter; word_done is a one-cycle pulse after the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            channel   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (!enable) begin
                // Dropping enable abandons any partial word.
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ws_edge) begin
                            state   <= ST_DELAY;
                            channel <= ws;
                        end
                    end
                    ST_DELAY: begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                    ST_SHIFT: begin
                        shift_reg <= {shift_reg[NUMBER_OF_BITS-2:0], data_in};
                        if (bit_cnt == LAST_BIT) begin
                            state     <= ST_IDLE;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output holding register with valid/ready handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_data    <= '0;
            sample_channel <= 1'b0;
            sample_valid   <= 1'b0;
        end else if (load) begin
            sample_data    <= shift_reg;
            sample_channel <= channel;
            sample_valid   <= 1'b1;
        end else if (accept) begin
            sample_valid   <= 1'b0;
        end
    end

    // Frame-buffer slot advances when a right-channel word is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (accept && sample_channel) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_controller.sv
// Directed bench for i2s_rx_controller at default parameters.
module tb_i2s_rx_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       data_in = 1'b0;
    logic       ws;
    logic [7:0] sample_data;
    logic       sample_channel;
    logic       sample_valid;
    logic       sample_ready = 1'b1;
    logic [3:0] wr_ptr;
    logic       overflow;
    logic       overflow_clear = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    i2s_rx_controller dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .data_in        (data_in),
        .ws             (ws),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .wr_ptr         (wr_ptr),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until ws changes; bounded.
    task automatic wait_toggle(output int n);
        logic w0;
        w0 = ws;
        n = 0;
        while (ws === w0 && n < 200) begin
            tick();
            n++;
        end
        check("ws_toggle_seen", {31'b0, ws !== w0}, 32'd1);
    endtask

    // Called just after the ws toggle edge E; ends just after E+10.
    task automatic drive_word(input logic [7:0] w);
        tick();
        data_in = 1'b1;
        tick();
        for (int i = 7; i >= 0; i--) begin
            data_in = w[i];
            tick();
        end
        data_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ws"},      {31'b0, ws}, 32'd0);
        check({tag, "_valid"},   {31'b0, sample_valid}, 32'd0);
        check({tag, "_data"},    {24'b0, sample_data}, 32'd0);
        check({tag, "_chan"},    {31'b0, sample_channel}, 32'd0);
        check({tag, "_wr_ptr"},  {28'b0, wr_ptr}, 32'd0);
        check({tag, "_ovf"},     {31'b0, overflow}, 32'd0);
    endtask

    // Release reset, confirm first ws rise at edge 32 and first word at edge 43.
    task automatic release_and_first(input logic [7:0] w);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 31) check("ws_before_32", {31'b0, ws}, 32'd0);
        end
        check("ws_at_32", {31'b0, ws}, 32'd1);
        check("no_valid_at_32", {31'b0, sample_valid}, 32'd0);
        drive_word(w);
        check("valid_low_e42", {31'b0, sample_valid}, 32'd0);
        tick();
        check("valid_high_e43", {31'b0, sample_valid}, 32'd1);
        check("first_data", {24'b0, sample_data}, {24'b0, w});
        check("first_chan", {31'b0, sample_channel}, 32'd1);
        tick();
        check("first_accepted", {31'b0, sample_valid}, 32'd0);
        check("first_wr_ptr", {28'b0, wr_ptr}, 32'd1);
    endtask

    int n;
    logic [3:0] exp_ptr [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};

    initial begin
        // Reset state and first right-channel word after reset.
        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        release_and_first(8'h5A);

        // Left A5 then right 3C with ready held high.
        wait_toggle(n);
        check("left_ws", {31'b0, ws}, 32'd0);
        drive_word(8'hA5);
        tick();
        check("a5_valid", {31'b0, sample_valid}, 32'd1);
        check("a5_data", {24'b0, sample_data}, 32'hA5);
        check("a5_chan", {31'b0, sample_channel}, 32'd0);
        tick();
        check("a5_wr_ptr", {28'b0, wr_ptr}, 32'd1);
        wait_toggle(n);
        drive_word(8'h3C);
        tick();
        check("3c_data", {24'b0, sample_data}, 32'h3C);
        check("3c_chan", {31'b0, sample_channel}, 32'd1);
        check("3c_ptr_before", {28'b0, wr_ptr}, 32'd1);
        tick();
        check("3c_accepted", {31'b0, sample_valid}, 32'd0);
        check("3c_wr_ptr", {28'b0, wr_ptr}, 32'd2);

        // Backpressure: second word dropped, clear coinciding with drop loses.
        sample_ready = 1'b0;
        wait_toggle(n);
        drive_word(8'h11);
        tick();
        check("hold_data", {24'b0, sample_data}, 32'h11);
        wait_toggle(n);
        drive_word(8'h22);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("drop_keeps_data", {24'b0, sample_data}, 32'h11);
        check("drop_keeps_chan", {31'b0, sample_channel}, 32'd0);
        check("drop_keeps_valid", {31'b0, sample_valid}, 32'd1);
        check("ovf_set_wins", {31'b0, overflow}, 32'd1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", {31'b0, overflow}, 32'd0);
        sample_ready = 1'b1;
        tick();
        check("held_accepted", {31'b0, sample_valid}, 32'd0);
        check("left_no_ptr", {28'b0, wr_ptr}, 32'd2);

        // Ready rises exactly on the completion of the next word.
        sample_ready = 1'b0;
        wait_toggle(n);
        drive_word(8'h44);
        tick();
        check("pend_data", {24'b0, sample_data}, 32'h44);
        wait_toggle(n);
        drive_word(8'h55);
        sample_ready = 1'b1;
        tick();
        check("swap_data", {24'b0, sample_data}, 32'h55);
        check("swap_chan", {31'b0, sample_channel}, 32'd1);
        check("swap_valid", {31'b0, sample_valid}, 32'd1);
        check("swap_no_ovf", {31'b0, overflow}, 32'd0);
        check("swap_ptr", {28'b0, wr_ptr}, 32'd2);
        tick();
        check("swap_ptr_after", {28'b0, wr_ptr}, 32'd3);

        // Enable low for 5 cycles during the 4th shift bit.
        wait_toggle(n);
        tick();
        data_in = 1'b1;
        tick();
        for (int i = 7; i >= 5; i--) begin
            data_in = n[0] ^ i[0];
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("ws_frozen", {31'b0, ws}, 32'd0);
        enable = 1'b1;
        tick();
        check("no_partial_valid", {31'b0, sample_valid}, 32'd0);
        wait_toggle(n);
        check("divider_frozen", n, 32'd26);
        check("no_valid_halfframe", {31'b0, sample_valid}, 32'd0);
        drive_word(8'h66);
        tick();
        check("resume_data", {24'b0, sample_data}, 32'h66);
        check("resume_chan", {31'b0, sample_channel}, 32'd1);
        tick();
        check("resume_ptr", {28'b0, wr_ptr}, 32'd4);

        // Reset during the 4th shift bit.
        wait_toggle(n);
        tick();
        data_in = 1'b1;
        tick();
        for (int i = 7; i >= 5; i--) begin
            data_in = i[0];
            tick();
        end
        data_in = 1'b0;
        reset = 1'b1;
        #1 check_reset_outputs("midshift");
        release_and_first(8'hC3);

        // Ten full frames: pointer walks through the wrap.
        for (int f = 0; f < 10; f++) begin
            wait_toggle(n);
            drive_word(8'(f));
            wait_toggle(n);
            drive_word(8'(f + 8'h80));
            tick();
            tick();
            check("frame_wr_ptr", {28'b0, wr_ptr}, {28'b0, exp_ptr[f]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
